// File: rtl/if_id_elastic_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_elastic_reg_if
// Bundles the IF-side and ID-side handshake/data signals of the IF/ID elastic
// register.
//   slave  : view taken by the buffer itself (consumes i_*, drives o_*)
//   master : view taken by whatever drives the buffer (IF/ID stages, bench)
// Signals:
//   i_valid / o_ready               IF-side handshake
//   i_inst, i_PC, i_PC_plus_4       IF-side payload
//   i_flush                         redirect: drop everything held and offered
//   o_valid / i_ready               ID-side handshake
//   o_inst, o_PC, o_PC_plus_4       ID-side payload
//   o_count                         occupancy (0, 1 or 2)
// -----------------------------------------------------------------------------
interface if_id_elastic_reg_if #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    logic                  i_valid;
    logic                  o_ready;
    logic [INST_WIDTH-1:0] i_inst;
    logic [PC_WIDTH-1:0]   i_PC;
    logic [PC_WIDTH-1:0]   i_PC_plus_4;
    logic                  i_flush;
    logic                  o_valid;
    logic                  i_ready;
    logic [INST_WIDTH-1:0] o_inst;
    logic [PC_WIDTH-1:0]   o_PC;
    logic [PC_WIDTH-1:0]   o_PC_plus_4;
    logic [1:0]            o_count;

    modport slave (
        input  i_valid, i_inst, i_PC, i_PC_plus_4, i_flush, i_ready,
        output o_ready, o_valid, o_inst, o_PC, o_PC_plus_4, o_count
    );

    modport master (
        output i_valid, i_inst, i_PC, i_PC_plus_4, i_flush, i_ready,
        input  o_ready, o_valid, o_inst, o_PC, o_PC_plus_4, o_count
    );
endinterface

// File: rtl/if_id_elastic_reg.sv
// -----------------------------------------------------------------------------
// if_id_elastic_reg
// Two-entry elastic (skid) buffer between the IF and ID stages. The main entry
// drives the ID-side outputs; the skid entry catches the one beat that IF can
// still deliver in the cycle ID stalls. Every output is a flop, so ID-side
// ready never reaches IF-side ready combinationally.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    if_id_elastic_reg_if.slave (handshakes, payload, flush, count)
// Parameters:
//   INST_WIDTH, PC_WIDTH  payload widths (must match the interface instance)
//   NOP_INST              instruction shown whenever o_valid is low
// -----------------------------------------------------------------------------
module if_id_elastic_reg #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    PC_WIDTH   = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000000
) (
    input logic                 clk,
    input logic                 reset,
    if_id_elastic_reg_if.slave  bus
);

    // Encoding is {skid_valid, main_valid}; ILLEGAL should never occur but is
    // given a recovery path so a corrupted state cannot wedge the pipeline.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ONE     = 2'b01,
        ILLEGAL = 2'b10,
        FULL    = 2'b11
    } state_t;

    state_t                state;
    logic [INST_WIDTH-1:0] main_inst;
    logic [PC_WIDTH-1:0]   main_pc;
    logic [PC_WIDTH-1:0]   main_pc4;
    logic [INST_WIDTH-1:0] skid_inst;
    logic [PC_WIDTH-1:0]   skid_pc;
    logic [PC_WIDTH-1:0]   skid_pc4;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_count;
    logic                  up;
    logic                  dn;

    // Handshake fires are taken from the registered copies of o_ready and
    // o_valid, exactly what the neighbouring stages see.
    assign up = bus.i_valid & out_ready;
    assign dn = out_valid & bus.i_ready;

    assign bus.o_valid     = out_valid;
    assign bus.o_ready     = out_ready;
    assign bus.o_count     = out_count;
    assign bus.o_inst      = main_inst;
    assign bus.o_PC        = main_pc;
    assign bus.o_PC_plus_4 = main_pc4;

    // Single state machine holding both entries and all registered outputs.
    // Flush outranks every other event: a concurrent dn still completes on the
    // ID side, but nothing is kept and any offered beat is dropped. Whenever
    // the main entry becomes empty its instruction is forced to NOP_INST while
    // the PC fields keep their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_inst <= NOP_INST;
            main_pc   <= '0;
            main_pc4  <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
            skid_pc4  <= '0;
            out_valid <= 1'b0;
            out_ready <= 1'b1;
            out_count <= 2'd0;
        end else if (bus.i_flush) begin
            state     <= EMPTY;
            main_inst <= NOP_INST;
            skid_inst <= '0;
            skid_pc   <= '0;
            skid_pc4  <= '0;
            out_valid <= 1'b0;
            out_ready <= 1'b1;
            out_count <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (up) begin
                        state     <= ONE;
                        main_inst <= bus.i_inst;
                        main_pc   <= bus.i_PC;
                        main_pc4  <= bus.i_PC_plus_4;
                        out_valid <= 1'b1;
                        out_ready <= 1'b1;
                        out_count <= 2'd1;
                    end
                end
                ONE: begin
                    if (up && dn) begin
                        main_inst <= bus.i_inst;
                        main_pc   <= bus.i_PC;
                        main_pc4  <= bus.i_PC_plus_4;
                    end else if (up) begin
                        state     <= FULL;
                        skid_inst <= bus.i_inst;
                        skid_pc   <= bus.i_PC;
                        skid_pc4  <= bus.i_PC_plus_4;
                        out_ready <= 1'b0;
                        out_count <= 2'd2;
                    end else if (dn) begin
                        state     <= EMPTY;
                        main_inst <= NOP_INST;
                        out_valid <= 1'b0;
                        out_count <= 2'd0;
                    end
                end
                FULL: begin
                    if (dn) begin
                        state     <= ONE;
                        main_inst <= skid_inst;
                        main_pc   <= skid_pc;
                        main_pc4  <= skid_pc4;
                        skid_inst <= '0;
                        skid_pc   <= '0;
                        skid_pc4  <= '0;
                        out_valid <= 1'b1;
                        out_ready <= 1'b1;
                        out_count <= 2'd1;
                    end
                end
                ILLEGAL: begin
                    state     <= ONE;
                    main_inst <= skid_inst;
                    main_pc   <= skid_pc;
                    main_pc4  <= skid_pc4;
                    skid_inst <= '0;
                    skid_pc   <= '0;
                    skid_pc4  <= '0;
                    out_valid <= 1'b1;
                    out_ready <= 1'b1;
                    out_count <= 2'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_elastic_reg
// Self-checking bench for if_id_elastic_reg. A queue-based reference model
// (FIFO of at most two beats, plus the last PC pair shown to ID) predicts every
// output; directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_if_id_elastic_reg;

    localparam int          IW  = 32;
    localparam int          PW  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } beat_t;

    logic clk;
    logic reset;
    int   checkCount;
    int   passCount;

    beat_t       q[$];
    logic [31:0] lastPc;
    logic [31:0] lastPc4;

    if_id_elastic_reg_if #(.INST_WIDTH(IW), .PC_WIDTH(PW)) bus ();

    if_id_elastic_reg #(
        .INST_WIDTH(IW),
        .PC_WIDTH  (PW),
        .NOP_INST  (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compares every output against what the FIFO model says ID should see.
    task automatic compareAll(input string tag);
        logic [31:0] expInst;
        logic [31:0] expPc;
        logic [31:0] expPc4;
        expInst = (q.size() > 0) ? q[0].inst : NOP;
        expPc   = (q.size() > 0) ? q[0].pc   : lastPc;
        expPc4  = (q.size() > 0) ? q[0].pc4  : lastPc4;
        checkOutput({tag, ".o_valid"}, 64'(bus.o_valid), 64'(q.size() > 0));
        checkOutput({tag, ".o_ready"}, 64'(bus.o_ready), 64'(q.size() < 2));
        checkOutput({tag, ".o_count"}, 64'(bus.o_count), 64'(q.size()));
        checkOutput({tag, ".o_inst"}, 64'(bus.o_inst), 64'(expInst));
        checkOutput({tag, ".o_PC"}, 64'(bus.o_PC), 64'(expPc));
        checkOutput({tag, ".o_PC_plus_4"}, 64'(bus.o_PC_plus_4), 64'(expPc4));
    endtask

    // FIFO semantics of one clock edge: flush empties everything; otherwise a
    // consumed head is popped and an accepted beat (room permitting) appended.
    task automatic modelStep(input logic v, input logic [31:0] inst,
                             input logic [31:0] pc, input logic flush,
                             input logic rdy);
        beat_t b;
        bit    accept;
        bit    consume;
        accept  = v && (q.size() < 2);
        consume = rdy && (q.size() > 0);
        b.inst  = inst;
        b.pc    = pc;
        b.pc4   = pc + 32'd4;
        if (flush) begin
            q.delete();
        end else begin
            if (consume) void'(q.pop_front());
            if (accept) q.push_back(b);
        end
        if (q.size() > 0) begin
            lastPc  = q[0].pc;
            lastPc4 = q[0].pc4;
        end
    endtask

    // Drives one cycle of inputs, advances model and DUT, checks at negedge.
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [31:0] inst, input logic [31:0] pc,
                                 input logic flush, input logic rdy);
        bus.i_valid     = v;
        bus.i_inst      = inst;
        bus.i_PC        = pc;
        bus.i_PC_plus_4 = pc + 32'd4;
        bus.i_flush     = flush;
        bus.i_ready     = rdy;
        @(posedge clk);
        modelStep(v, inst, pc, flush, rdy);
        @(negedge clk);
        compareAll(tag);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        lastPc     = '0;
        lastPc4    = '0;
        reset      = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_inst      = '0;
        bus.i_PC        = '0;
        bus.i_PC_plus_4 = '0;
        bus.i_flush     = 1'b0;
        bus.i_ready     = 1'b0;

        #12;
        compareAll("reset");
        reset = 1'b0;

        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) begin
            applyStimulus("stream", 1'b1, 32'h11 * (i + 1), 32'(4 * i), 1'b0, 1'b1);
        end
        applyStimulus("stream_tail", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] stall and skid");
        applyStimulus("stall_a", 1'b1, 32'hA1, 32'h100, 1'b0, 1'b0);
        applyStimulus("stall_b", 1'b1, 32'hB2, 32'h104, 1'b0, 1'b0);
        applyStimulus("stall_c", 1'b1, 32'hC3, 32'h108, 1'b0, 1'b0);
        checkOutput("stall_full_count", 64'(bus.o_count), 64'd2);
        checkOutput("stall_hold_inst", 64'(bus.o_inst), 64'hA1);
        applyStimulus("drain_1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("drain_second_inst", 64'(bus.o_inst), 64'hB2);
        applyStimulus("drain_2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] flush while full");
        applyStimulus("fill_a", 1'b1, 32'hD1, 32'h200, 1'b0, 1'b0);
        applyStimulus("fill_b", 1'b1, 32'hD2, 32'h204, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 32'h55, 32'h208, 1'b1, 1'b0);
        checkOutput("flush_inst_nop", 64'(bus.o_inst), 64'(NOP));
        checkOutput("flush_pc_hold", 64'(bus.o_PC), 64'h200);
        applyStimulus("post_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] drain to empty");
        applyStimulus("single", 1'b1, 32'hABCD, 32'h300, 1'b0, 1'b1);
        applyStimulus("empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("empty_valid", 64'(bus.o_valid), 64'd0);
        checkOutput("empty_inst_nop", 64'(bus.o_inst), 64'(NOP));

        $display("[TB] reset mid-stream");
        applyStimulus("pre_rst_a", 1'b1, 32'hE1, 32'h400, 1'b0, 1'b0);
        applyStimulus("pre_rst_b", 1'b1, 32'hE2, 32'h404, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        lastPc  = '0;
        lastPc4 = '0;
        compareAll("async_reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("post_rst", 1'b1, 32'hF0, 32'h500, 1'b0, 1'b1);

        $display("[TB] randomized run");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), $urandom,
                          {$urandom_range(0, 32'h3FFF), 2'b00},
                          1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
